cam_trigger_gen: RTL

Parametrised multi-camera trigger generator. It replaces the single shared cam_trigger with NUM_CAMS independently phased trigger outputs, one per sim_python/PYTHON sensor channel. Frame events come from one of three sources: a free-running period counter, divided IMU sync pulses, or a software single-shot. Sits inside top on clk125 and is configured from the reg_ram/PIO register path.

---
 rtl/cam_trigger_gen.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cam_trigger_gen.sv
// Multi-camera trigger generator: a single frame-event source (free-run, IMU
// sync or software shot) fans out to NUM_CAMS independently delayed pulses.

module cam_trigger_chan #(
  parameter int PERIOD_W = 24,
  parameter int PULSE_W  = 16
) (
  input  logic                c,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                start,
  input  logic [PERIOD_W-1:0] offset,
  input  logic [PULSE_W-1:0]  pulse_len,
  output logic                trigger,
  output logic                active
);
  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] dly;
  logic [PULSE_W-1:0]  pls;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Zero offset skips DELAY so the pulse starts the cycle after the event.
  always_comb begin
    state_nxt = state;
    if (!enable) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = (offset == '0) ? PULSE : DELAY;
        DELAY:   if (dly == PERIOD_W'(1)) state_nxt = PULSE;
        PULSE:   if (pls == PULSE_W'(1)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      dly <= '0;
      pls <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        dly <= offset;
        pls <= (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
      end
    end else begin
      if (state == DELAY) dly <= dly - PERIOD_W'(1);
      if (state == PULSE) pls <= pls - PULSE_W'(1);
    end
  end

  always_comb begin
    trigger = (state == PULSE);
    active  = (state != IDLE);
  end
endmodule

module cam_trigger_gen #(
  parameter int NUM_CAMS = 2,
  parameter int PERIOD_W = 24,
  parameter int PULSE_W  = 16,
  parameter int DIV_W    = 8
) (
  input  logic                         c,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic [PERIOD_W-1:0]          period,
  input  logic [PULSE_W-1:0]           pulse_len,
  input  logic [NUM_CAMS*PERIOD_W-1:0] offset,
  input  logic                         sync_in,
  input  logic [DIV_W-1:0]             sync_div,
  input  logic                         sw_fire,
  output logic [NUM_CAMS-1:0]          trigger,
  output logic                         busy,
  output logic [31:0]                  frame_count,
  output logic                         overrun
);
  localparam logic [1:0] M_FREE = 2'd0;
  localparam logic [1:0] M_SYNC = 2'd1;
  localparam logic [1:0] M_SHOT = 2'd2;

  logic [PERIOD_W-1:0] per_cnt, per_lat, per_eff;
  logic [DIV_W-1:0]    div_cnt;
  logic                sync_s1, sync_s2, sync_d, sync_edge;
  logic                sw_d, sw_edge;
  logic                ev, accept;
  logic [NUM_CAMS-1:0] active;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1   <= 1'b0;
      sync_s2   <= 1'b0;
      sync_d    <= 1'b0;
      sync_edge <= 1'b0;
      sw_d      <= 1'b0;
      sw_edge   <= 1'b0;
    end else begin
      sync_s1   <= sync_in;
      sync_s2   <= sync_s1;
      sync_d    <= sync_s2;
      sync_edge <= sync_s2 & ~sync_d;
      sw_d      <= sw_fire;
      sw_edge   <= sw_fire & ~sw_d;
    end
  end

  // A new period is only picked up when the counter sits at 0 (the wrap point).
  always_comb per_eff = (per_cnt == '0) ? period : per_lat;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      per_lat <= '0;
    end else if (!enable || mode != M_FREE || per_eff < PERIOD_W'(2)) begin
      per_cnt <= '0;
    end else begin
      per_lat <= per_eff;
      per_cnt <= (per_cnt >= per_eff - PERIOD_W'(1)) ? '0 : per_cnt + PERIOD_W'(1);
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n)                         div_cnt <= '0;
    else if (!enable || mode != M_SYNC) div_cnt <= '0;
    else if (sync_edge)                 div_cnt <= (div_cnt == sync_div) ? '0 : div_cnt + DIV_W'(1);
  end

  always_comb begin
    ev = 1'b0;
    if (enable) begin
      case (mode)
        M_FREE:  ev = (per_cnt == '0) && (period >= PERIOD_W'(2));
        M_SYNC:  ev = sync_edge && (div_cnt == sync_div);
        M_SHOT:  ev = sw_edge;
        default: ev = 1'b0;
      endcase
    end
    accept = ev && !busy;
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      if (accept)         frame_count <= frame_count + 32'd1;
      if (!enable)        overrun <= 1'b0;
      else if (ev && busy) overrun <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CAMS; k++) begin : g_chan
    cam_trigger_chan #(.PERIOD_W(PERIOD_W), .PULSE_W(PULSE_W)) u_chan (
      .c         (c),
      .rst_n     (rst_n),
      .enable    (enable),
      .start     (accept),
      .offset    (offset[k*PERIOD_W +: PERIOD_W]),
      .pulse_len (pulse_len),
      .trigger   (trigger[k]),
      .active    (active[k])
    );
  end

  always_comb busy = |active;
endmodule
